ila_trigger_unit: RTL

ILA_TRIGGER_UNIT -- requirements
Module: ila_trigger_unit

---
 rtl/ila_trigger_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ila_trigger_unit.sv
// rtl/ila_trigger_unit.sv - per-channel mask/compare trigger with occurrence counters for an ILA
// Optional two-stage trigger sequencer is built when ILA_TRIG_SEQ_EN is defined.
module ila_trigger_unit #(
    parameter int SIGNAL_W  = 32,
    parameter int TRIGGER_W = 4,
    parameter int CNT_W     = 16,
    localparam int SEL_W    = (TRIGGER_W > 1) ? $clog2(TRIGGER_W) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic [SIGNAL_W-1:0]  signal,
    input  logic                 cfg_wr,
    input  logic [SEL_W-1:0]     cfg_sel,
    input  logic [SIGNAL_W-1:0]  cfg_value,
    input  logic [SIGNAL_W-1:0]  cfg_mask,
    input  logic [1:0]           cfg_mode,
    input  logic [CNT_W-1:0]     cfg_count,
`ifdef ILA_TRIG_SEQ_EN
    input  logic                 arm,
    input  logic [CNT_W-1:0]     seq_win,
    output logic                 seq_trigger,
    output logic [1:0]           seq_state,
`endif
    output logic [TRIGGER_W-1:0] trigger
);

    for (genvar g = 0; g < TRIGGER_W; g++) begin : g_ch
        logic [SIGNAL_W-1:0] r_value;
        logic [SIGNAL_W-1:0] r_mask;
        logic [SIGNAL_W-1:0] r_prev_masked;
        logic [1:0]          r_mode;
        logic [CNT_W-1:0]    r_count;
        logic [CNT_W-1:0]    r_hit;
        logic                r_prev_match;
        logic                r_trig;
        logic [SIGNAL_W-1:0] w_masked;
        logic [CNT_W-1:0]    w_hit_inc;
        logic                w_match;
        logic                w_cond;
        logic                w_sel;

        assign w_masked  = signal & r_mask;
        assign w_match   = ((signal ^ r_value) & r_mask) == '0;
        assign w_hit_inc = r_hit + CNT_W'(1);
        // Out-of-range selects never equal any channel index, so they are dropped here.
        assign w_sel     = cfg_wr && (int'(cfg_sel) == g);

        always_comb begin
            w_cond = 1'b0;
            case (r_mode)
                2'b00:   w_cond = w_match;
                2'b01:   w_cond = w_match & ~r_prev_match;
                2'b10:   w_cond = ~w_match & r_prev_match;
                default: w_cond = (w_masked != r_prev_masked);
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_value       <= '0;
                r_mask        <= '0;
                r_mode        <= 2'b00;
                r_count       <= '0;
                r_hit         <= '0;
                r_prev_match  <= 1'b0;
                r_prev_masked <= '0;
                r_trig        <= 1'b0;
            end else begin
                r_prev_match  <= w_match;
                r_prev_masked <= w_masked;
                r_trig        <= 1'b0;
                if (w_sel) begin
                    r_value <= cfg_value;
                    r_mask  <= cfg_mask;
                    r_mode  <= cfg_mode;
                    r_count <= cfg_count;
                    r_hit   <= '0;
                end else if (clear) begin
                    r_hit <= '0;
                end else if (en && (r_count != '0) && w_cond) begin
                    if (w_hit_inc == r_count) begin
                        r_trig <= 1'b1;
                        r_hit  <= '0;
                    end else begin
                        r_hit <= w_hit_inc;
                    end
                end
            end
        end

        assign trigger[g] = r_trig;
    end

`ifdef ILA_TRIG_SEQ_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_A = 2'd1,
        S_WAIT_B = 2'd2,
        S_FIRE   = 2'd3
    } seq_state_t;

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [CNT_W-1:0] r_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_win   <= '0;
        end else begin
            r_state <= w_next;
            r_win   <= (r_state == S_WAIT_B) ? r_win + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (arm) w_next = S_WAIT_A;
            S_WAIT_A: if (trigger[0]) w_next = S_WAIT_B;
            // A second-stage hit on the expiry cycle still fires.
            S_WAIT_B: begin
                if (trigger[1])
                    w_next = S_FIRE;
                else if ((seq_win != '0) && (r_win == seq_win - CNT_W'(1)))
                    w_next = S_WAIT_A;
            end
            default:  w_next = S_IDLE;
        endcase
        if (clear) w_next = S_IDLE;
    end

    assign seq_state   = r_state;
    assign seq_trigger = (r_state == S_FIRE);
`endif

endmodule
